// File: rtl/sequence_capture_if.sv
// Player-side capture bus: start/expected/keys/tick in, status and per-digit echo out.
// The master side drives the player inputs; the slave side is the capture block.
interface sequence_capture_if #(
    parameter int unsigned SEQ_W = 18
);
    logic             start;
    logic [SEQ_W-1:0] expected;
    logic             key_one;
    logic             key_zero;
    logic             tick;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SEQ_W-1:0] entered;
    logic [4:0]       digit_idx;
    logic             echo_draw;
    logic [4:0]       echo_dec;
    logic             echo_bit;

    modport master (
        output start, expected, key_one, key_zero, tick,
        input  busy, done, pass, entered, digit_idx, echo_draw, echo_dec, echo_bit
    );

    modport slave (
        input  start, expected, key_one, key_zero, tick,
        output busy, done, pass, entered, digit_idx, echo_draw, echo_dec, echo_bit
    );
endinterface

// File: rtl/sequence_capture.sv
// Collects one bit per key press LSB-first and compares the word with the expected sequence.
// Define SEQ_CAPTURE_EARLY_FAIL_EN to end the capture on the first mismatching digit.
module sequence_capture #(
    parameter int unsigned SEQ_W         = 18,
    parameter int unsigned SEQ_LEN       = 17,
    parameter int unsigned TIMEOUT_TICKS = 10
) (
    input logic                clock,
    input logic                reset,
    sequence_capture_if.slave  bus
);
    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [SEQ_W:0]   LEN_ONE  = (SEQ_W+1)'(1);
    localparam logic [SEQ_W-1:0] LEN_MASK = SEQ_W'((LEN_ONE << SEQ_LEN) - LEN_ONE);

    typedef enum logic [1:0] {IDLE, ENTER, CHECK, DONE} state_e;

    state_e             state_q, state_d;
    logic [SEQ_W-1:0]   exp_q, exp_d;
    logic [SEQ_W-1:0]   entered_q, entered_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pass_q, pass_d;
    logic               echo_draw_q, echo_draw_d;
    logic [IDX_W-1:0]   echo_dec_q, echo_dec_d;
    logic               echo_bit_q, echo_bit_d;
    logic               busy_q, done_q;
    logic [2:0]         one_sync_q, zero_sync_q;

    logic press_one_c, press_zero_c, press_ok_c;

    // Two synchronizer stages, third stage for rising-edge detect
    assign press_one_c  = one_sync_q[1]  & ~one_sync_q[2];
    assign press_zero_c = zero_sync_q[1] & ~zero_sync_q[2];
    assign press_ok_c   = press_one_c ^ press_zero_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        entered_d   = entered_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pass_d      = pass_q;
        echo_draw_d = 1'b0;
        echo_dec_d  = echo_dec_q;
        echo_bit_d  = echo_bit_q;

        if (bus.start) begin
            state_d   = ENTER;
            exp_d     = bus.expected;
            entered_d = '0;
            idx_d     = '0;
            cnt_d     = '0;
        end else begin
            unique case (state_q)
                ENTER: begin
                    if (press_ok_c) begin
                        entered_d[idx_q] = press_one_c;
                        echo_draw_d      = 1'b1;
                        echo_dec_d       = idx_q;
                        echo_bit_d       = press_one_c;
                        idx_d            = idx_q + IDX_W'(1);
                        cnt_d            = '0;
                        if (idx_q == IDX_W'(SEQ_LEN - 1)) state_d = CHECK;
`ifdef SEQ_CAPTURE_EARLY_FAIL_EN
                        if (press_one_c != exp_q[idx_q]) begin
                            state_d = DONE;
                            pass_d  = 1'b0;
                        end
`endif
                    end else if (bus.tick) begin
                        if (cnt_q != CNT_W'(TIMEOUT_TICKS)) cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(TIMEOUT_TICKS)) begin
                            state_d = DONE;
                            pass_d  = 1'b0;
                        end
                    end
                end
                CHECK: begin
                    pass_d  = (((entered_q ^ exp_q) & LEN_MASK) == '0);
                    state_d = DONE;
                end
                default: ;
            endcase
        end
    end

    // Datapath and status registers; status follows the state register by one cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_q       <= '0;
            entered_q   <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            pass_q      <= 1'b0;
            echo_draw_q <= 1'b0;
            echo_dec_q  <= '0;
            echo_bit_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            one_sync_q  <= '0;
            zero_sync_q <= '0;
        end else begin
            exp_q       <= exp_d;
            entered_q   <= entered_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pass_q      <= pass_d;
            echo_draw_q <= echo_draw_d;
            echo_dec_q  <= echo_dec_d;
            echo_bit_q  <= echo_bit_d;
            busy_q      <= (state_q == ENTER) || (state_q == CHECK);
            done_q      <= (state_q == DONE);
            one_sync_q  <= {one_sync_q[1:0], bus.key_one};
            zero_sync_q <= {zero_sync_q[1:0], bus.key_zero};
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.entered   = entered_q;
    assign bus.digit_idx = idx_q;
    assign bus.echo_draw = echo_draw_q;
    assign bus.echo_dec  = echo_dec_q;
    assign bus.echo_bit  = echo_bit_q;
endmodule
